// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier result collector.
package mult_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_e;

    localparam int DEFAULT_RESULT_WIDTH = 65;
    localparam int STATS_WIDTH          = 16;

endpackage

// File: rtl/mult_result_fifo.sv
// Show-ahead FIFO holding captured products; head word is always visible on rd_data.
module mult_result_fifo #(
    parameter  int RESULT_WIDTH = 65,
    parameter  int DEPTH        = 4,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [RESULT_WIDTH-1:0] wr_data,
    input  logic                    pop,
    output logic [RESULT_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]        count
);

    logic [RESULT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    push_ok;
    logic                    pop_ok;

    // Requests are qualified here so a stray pop on empty or push on full is harmless.
    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_result_collector.sv
// Completes the multiplier Done/Ack handshake and queues products for a valid/ready consumer.
// Optional MULTRC_STATS_EN adds the oTotal captured-product counter.
module mult_result_collector
    import mult_pkg::*;
#(
    parameter  int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
    parameter  int DEPTH        = 4,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iDone,
    input  logic [RESULT_WIDTH-1:0] iResult,
    output logic                    oAck,
    output logic [RESULT_WIDTH-1:0] oData,
    output logic                    oValid,
    input  logic                    iReady,
    output logic [CNT_W-1:0]        oCount,
`ifdef MULTRC_STATS_EN
    output logic [STATS_WIDTH-1:0]  oTotal,
`endif
    output state_e                  oState
);

    state_e state;
    state_e state_nxt;
    logic   ack_nxt;
    logic   push;
    logic   pop;

    assign oState = state;
    assign oValid = (oCount != '0);
    assign pop    = oValid && iReady;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
            oAck  <= 1'b0;
        end else begin
            state <= state_nxt;
            oAck  <= ack_nxt;
        end
    end

    // Capture only from S_IDLE so a Done held across many cycles is taken once.
    always_comb begin
        state_nxt = state;
        ack_nxt   = oAck;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                ack_nxt = 1'b0;
                if (iDone && (oCount != CNT_W'(DEPTH))) begin
                    push      = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                ack_nxt = 1'b1;
                if (!iDone) begin
                    ack_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                ack_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    mult_result_fifo #(
        .RESULT_WIDTH (RESULT_WIDTH),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst     (Reset),
        .push    (push),
        .wr_data (iResult),
        .pop     (pop),
        .rd_data (oData),
        .count   (oCount)
    );

`ifdef MULTRC_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oTotal <= '0;
        end else if (push) begin
            oTotal <= oTotal + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_result_collector.sv
// Self-checking bench for mult_result_collector: directed scenarios plus a randomized multiplier/consumer.
module tb_mult_result_collector;
    import mult_pkg::*;

    localparam int W     = DEFAULT_RESULT_WIDTH;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iDone = 1'b0;
    logic [W-1:0]  iResult = '0;
    logic          iReady = 1'b0;
    logic          oAck;
    logic [W-1:0]  oData;
    logic          oValid;
    logic [CW-1:0] oCount;
    state_e        oState;
`ifdef MULTRC_STATS_EN
    logic [STATS_WIDTH-1:0] oTotal;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: stored words in order, whether a handshake is open, products taken.
    logic [W-1:0] exp_q[$];
    bit           m_ack   = 1'b0;
    int           m_total = 0;

    mult_result_collector #(.RESULT_WIDTH(W), .DEPTH(DEPTH)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iDone   (iDone),
        .iResult (iResult),
        .oAck    (oAck),
        .oData   (oData),
        .oValid  (oValid),
        .iReady  (iReady),
        .oCount  (oCount),
`ifdef MULTRC_STATS_EN
        .oTotal  (oTotal),
`endif
        .oState  (oState)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: the model applies the rules to the inputs seen at the edge.
    task automatic step();
        bit push;
        bit pop;
        @(posedge Clock);
        if (Reset) begin
            exp_q.delete();
            m_ack   = 1'b0;
            m_total = 0;
        end else begin
            pop  = (exp_q.size() != 0) && iReady;
            push = !m_ack && iDone && (exp_q.size() < DEPTH);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                exp_q.push_back(iResult);
                m_total = (m_total + 1) % 65536;
                m_ack   = 1'b1;
            end else if (m_ack && !iDone) begin
                m_ack = 1'b0;
            end
        end
        @(negedge Clock);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ack"},   W'(oAck),   W'(m_ack));
        check({tag, ".count"}, W'(oCount), W'(exp_q.size()));
        check({tag, ".valid"}, W'(oValid), W'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, ".data"}, oData, exp_q[0]);
`ifdef MULTRC_STATS_EN
        check({tag, ".total"}, W'(oTotal), W'(m_total));
`endif
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        iDone = 1'b0;
        iReady = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        Reset = 1'b0;
    endtask

    task automatic capture(input logic [W-1:0] value, input string tag);
        iDone   = 1'b1;
        iResult = value;
        step();
        check_all({tag, ".cap"});
        iDone = 1'b0;
        step();
        check_all({tag, ".rel"});
    endtask

    initial begin
        // Reset state
        do_reset(2);
        check_all("reset");
        check("reset.data0", oData, W'(0));
        check("reset.state", W'(oState), W'(S_IDLE));

        // Basic capture of 15
        capture(W'(15), "basic");
        check("basic.data15", oData, W'(15));

        // Held Done: one capture only
        do_reset(2);
        iDone   = 1'b1;
        iResult = W'(42);
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("held");
        end
        check("held.count1", W'(oCount), W'(1));
        iDone = 1'b0;
        step();
        check_all("held.rel");

        // Full stall, then one pop frees a slot for the fifth product
        do_reset(1);
        for (int k = 1; k <= 4; k++) capture(W'(k * k), "fill");
        iDone   = 1'b1;
        iResult = W'(25);
        step();
        check_all("stall");
        check("stall.ack0", W'(oAck), W'(0));
        check("stall.count4", W'(oCount), W'(4));
        iReady = 1'b1;
        step();
        check_all("stall.pop");
        check("stall.noack", W'(oAck), W'(0));
        iReady = 1'b0;
        step();
        check_all("stall.retry");
        check("stall.ack1", W'(oAck), W'(1));
        check("stall.head4", oData, W'(4));
        iDone = 1'b0;
        step();
        check_all("stall.rel");

        // Simultaneous push and pop at count 2
        do_reset(1);
        capture(W'(100), "sim");
        capture(W'(200), "sim");
        iReady  = 1'b1;
        iDone   = 1'b1;
        iResult = W'(300);
        step();
        check_all("sim.both");
        check("sim.count2", W'(oCount), W'(2));
        iDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("sim.drain");
        end
        iReady = 1'b0;

        // Reset while in S_ACK with three entries stored
        do_reset(1);
        capture(W'(7), "midrst");
        capture(W'(8), "midrst");
        iDone   = 1'b1;
        iResult = W'(9);
        step();
        check_all("midrst.ack");
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        iDone = 1'b0;
        check_all("midrst");
        check("midrst.ack0", W'(oAck), W'(0));
        check("midrst.count0", W'(oCount), W'(0));

`ifdef MULTRC_STATS_EN
        do_reset(1);
        iReady = 1'b1;
        for (int k = 0; k < 5; k++) capture(W'($urandom), "stats");
        check("stats.total5", W'(oTotal), W'(5));
        do_reset(1);
        check("stats.total0", W'(oTotal), W'(0));
        iReady = 1'b0;
`endif

        // Randomized multiplier and consumer
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            iReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                Reset = 1'b1;
                iDone = 1'b0;
            end else begin
                Reset = 1'b0;
                if (iDone && oAck) begin
                    if ($urandom_range(0, 1) == 0) iDone = 1'b0;
                end else if (!iDone && !oAck && $urandom_range(0, 2) == 0) begin
                    iDone   = 1'b1;
                    iResult = {1'($urandom), $urandom, $urandom};
                end
            end
            step();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
